// File: rtl/execute_in_operand_queue_if.sv
// Producer/consumer bundle for the execute-stage operand queue.
// slave = queue side, master = surrounding pipeline side.
interface execute_in_operand_queue_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6
);
    // Valid/ready: a beat transfers on any rising edge where valid and ready are both high;
    // the sender holds its payload steady while valid=1 and ready=0.
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] E_control;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic              bypass_alu_1;
    logic              bypass_alu_2;
    logic              bypass_mem_1;
    logic              bypass_mem_2;
    logic [DATA_W-1:0] alu_result_fb;
    logic [DATA_W-1:0] Mem_Bypass_Val;
    logic              Mem_Control_in;
    logic [1:0]        W_Control_in;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] opA_out;
    logic [DATA_W-1:0] opB_out;
    logic [CTRL_W-1:0] E_control_out;
    logic [DATA_W-1:0] IR_out;
    logic [DATA_W-1:0] npc_out;
    logic              Mem_Control_out;
    logic [1:0]        W_Control_out;

    modport slave (
        input  in_valid, E_control, IR, npc_in, VSR1, VSR2,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               alu_result_fb, Mem_Bypass_Val, Mem_Control_in, W_Control_in, out_ready,
        output in_ready, out_valid, opA_out, opB_out, E_control_out, IR_out, npc_out,
               Mem_Control_out, W_Control_out
    );

    modport master (
        output in_valid, E_control, IR, npc_in, VSR1, VSR2,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               alu_result_fb, Mem_Bypass_Val, Mem_Control_in, W_Control_in, out_ready,
        input  in_ready, out_valid, opA_out, opB_out, E_control_out, IR_out, npc_out,
               Mem_Control_out, W_Control_out
    );
endinterface

// File: rtl/execute_in_operand_queue.sv
// Execute-stage input queue: resolves operand bypass at capture and buffers DEPTH packets.
// Optional macro EXEC_IN_BYPASS_CONFLICT_EN enables the sticky ALU/MEM bypass conflict flag.
module execute_in_operand_queue #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    execute_in_operand_queue_if.slave     bus,
    output logic [CNT_W-1:0]              count,
    output logic                          conflict_err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [CTRL_W-1:0] e_control;
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] npc;
        logic              mem_control;
        logic [1:0]        w_control;
    } pkt_t;

    pkt_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    pkt_t             in_pkt;
    pkt_t             head_pkt;
    logic             push, pop, not_empty;

    // ALU bypass wins over MEM bypass when both are requested for one operand.
    always_comb begin
        in_pkt             = '0;
        in_pkt.op_a        = bus.bypass_alu_1 ? bus.alu_result_fb :
                             bus.bypass_mem_1 ? bus.Mem_Bypass_Val : bus.VSR1;
        in_pkt.op_b        = bus.bypass_alu_2 ? bus.alu_result_fb :
                             bus.bypass_mem_2 ? bus.Mem_Bypass_Val : bus.VSR2;
        in_pkt.e_control   = bus.E_control;
        in_pkt.ir          = bus.IR;
        in_pkt.npc         = bus.npc_in;
        in_pkt.mem_control = bus.Mem_Control_in;
        in_pkt.w_control   = bus.W_Control_in;
    end

    assign not_empty    = (count_q != '0);
    assign bus.in_ready = (count_q != CNT_W'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = not_empty & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: empty entries are never visible at the outputs.
    always_ff @(posedge clock) begin
        if (push && !reset && !flush) mem_q[wr_ptr_q] <= in_pkt;
    end

    assign head_pkt            = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.out_valid       = not_empty;
    assign bus.opA_out         = head_pkt.op_a;
    assign bus.opB_out         = head_pkt.op_b;
    assign bus.E_control_out   = head_pkt.e_control;
    assign bus.IR_out          = head_pkt.ir;
    assign bus.npc_out         = head_pkt.npc;
    assign bus.Mem_Control_out = head_pkt.mem_control;
    assign bus.W_Control_out   = head_pkt.w_control;
    assign count               = count_q;

`ifdef EXEC_IN_BYPASS_CONFLICT_EN
    logic conflict_q;

    // Sticky across flush; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else if (push && ((bus.bypass_alu_1 && bus.bypass_mem_1) ||
                              (bus.bypass_alu_2 && bus.bypass_mem_2))) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict_err = conflict_q;
`else
    assign conflict_err = 1'b0;
`endif
endmodule

// File: tb/tb_execute_in_operand_queue.sv
// Bench for execute_in_operand_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_execute_in_operand_queue;
    localparam int DATA_W = 16;
    localparam int CTRL_W = 6;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PKT_W  = 4 * DATA_W + CTRL_W + 3;
`ifdef EXEC_IN_BYPASS_CONFLICT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             conflict_err;

    logic [PKT_W-1:0] exp_q[$];
    logic             exp_conflict;
    int               n_tests = 0;
    int               n_fail  = 0;

    execute_in_operand_queue_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    execute_in_operand_queue #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .count        (count),
        .conflict_err (conflict_err)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pick(input logic use_alu, input logic use_mem,
                                               input logic [DATA_W-1:0] alu_v,
                                               input logic [DATA_W-1:0] mem_v,
                                               input logic [DATA_W-1:0] reg_v);
        if (use_alu) return alu_v;
        if (use_mem) return mem_v;
        return reg_v;
    endfunction

    task automatic check_all();
        logic [PKT_W-1:0] head;
        logic [PKT_W-1:0] exp_head;
        head = {bus.opA_out, bus.opB_out, bus.E_control_out, bus.IR_out, bus.npc_out,
                bus.Mem_Control_out, bus.W_Control_out};
        exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("count", 128'(count), 128'(exp_q.size()));
        check("in_ready", 128'(bus.in_ready), 128'(exp_q.size() != DEPTH));
        check("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
        check("head", 128'(head), 128'(exp_head));
        check("conflict_err", 128'(conflict_err), 128'(exp_conflict));
    endtask

    // ---------------- drivers ----------------
    task automatic set_idle();
        reset              = 1'b0;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.E_control      = '0;
        bus.IR             = '0;
        bus.npc_in         = '0;
        bus.VSR1           = '0;
        bus.VSR2           = '0;
        bus.bypass_alu_1   = 1'b0;
        bus.bypass_alu_2   = 1'b0;
        bus.bypass_mem_1   = 1'b0;
        bus.bypass_mem_2   = 1'b0;
        bus.alu_result_fb  = '0;
        bus.Mem_Bypass_Val = '0;
        bus.Mem_Control_in = 1'b0;
        bus.W_Control_in   = '0;
    endtask

    task automatic set_random();
        reset              = ($urandom_range(0, 99) == 0);
        flush              = ($urandom_range(0, 24) == 0);
        bus.in_valid       = ($urandom_range(0, 9) < 7);
        bus.out_ready      = ($urandom_range(0, 9) < 5);
        bus.E_control      = CTRL_W'($urandom);
        bus.IR             = DATA_W'($urandom);
        bus.npc_in         = DATA_W'($urandom);
        bus.VSR1           = DATA_W'($urandom);
        bus.VSR2           = DATA_W'($urandom);
        bus.bypass_alu_1   = ($urandom_range(0, 3) == 0);
        bus.bypass_alu_2   = ($urandom_range(0, 3) == 0);
        bus.bypass_mem_1   = ($urandom_range(0, 3) == 0);
        bus.bypass_mem_2   = ($urandom_range(0, 3) == 0);
        bus.alu_result_fb  = DATA_W'($urandom);
        bus.Mem_Bypass_Val = DATA_W'($urandom);
        bus.Mem_Control_in = 1'($urandom_range(0, 1));
        bus.W_Control_in   = 2'($urandom_range(0, 3));
    endtask

    // One clock: model advances on the rising edge, outputs are checked on the falling edge.
    task automatic tick();
        logic [PKT_W-1:0] pkt;
        bit push, pop, conf;
        push = bus.in_valid && (exp_q.size() != DEPTH);
        pop  = bus.out_ready && (exp_q.size() != 0);
        pkt  = {pick(bus.bypass_alu_1, bus.bypass_mem_1, bus.alu_result_fb, bus.Mem_Bypass_Val, bus.VSR1),
                pick(bus.bypass_alu_2, bus.bypass_mem_2, bus.alu_result_fb, bus.Mem_Bypass_Val, bus.VSR2),
                bus.E_control, bus.IR, bus.npc_in, bus.Mem_Control_in, bus.W_Control_in};
        conf = CONF_EN && push && ((bus.bypass_alu_1 && bus.bypass_mem_1) ||
                                   (bus.bypass_alu_2 && bus.bypass_mem_2));
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            exp_conflict = 1'b0;
        end else begin
            if (conf) exp_conflict = 1'b1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(pkt);
            end
        end
        @(negedge clock);
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_count", 128'(count), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // Plain register operands, one-cycle latency.
        bus.in_valid = 1'b1;
        bus.VSR1 = 16'h1234;
        bus.VSR2 = 16'h00FF;
        tick();
        check("t1_valid", 128'(bus.out_valid), 128'(1));
        check("t1_opA", 128'(bus.opA_out), 128'(16'h1234));
        check("t1_opB", 128'(bus.opB_out), 128'(16'h00FF));
        set_idle();
        bus.out_ready = 1'b1;
        tick();

        // ALU bypass on A, MEM bypass on B.
        set_idle();
        bus.in_valid = 1'b1;
        bus.VSR1 = 16'h1111;
        bus.VSR2 = 16'h2222;
        bus.bypass_alu_1 = 1'b1;
        bus.alu_result_fb = 16'hBEEF;
        bus.bypass_mem_2 = 1'b1;
        bus.Mem_Bypass_Val = 16'h0042;
        tick();
        check("t2_opA", 128'(bus.opA_out), 128'(16'hBEEF));
        check("t2_opB", 128'(bus.opB_out), 128'(16'h0042));
        set_idle();
        bus.out_ready = 1'b1;
        tick();

        // Fill to full, reject a fifth packet, drain in order.
        set_idle();
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            bus.IR = DATA_W'(k);
            tick();
        end
        check("t3_full_count", 128'(count), 128'(4));
        check("t3_full_ready", 128'(bus.in_ready), 128'(0));
        set_idle();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t3_drain_ir", 128'(bus.IR_out), 128'(k));
            tick();
        end
        check("t3_empty", 128'(bus.out_valid), 128'(0));

        // Steady push+pop at occupancy 2 across pointer wrap.
        set_idle();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.IR = DATA_W'(16'h10 + k);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.IR = DATA_W'(16'h12 + k);
            check("t4_order", 128'(bus.IR_out), 128'(16'h10 + k));
            tick();
            check("t4_count", 128'(count), 128'(2));
        end

        // Flush at occupancy 3 beats a simultaneous push and pop.
        bus.out_ready = 1'b0;
        bus.IR = 16'h0099;
        tick();
        check("t5_pre_count", 128'(count), 128'(3));
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("t5_count", 128'(count), 128'(0));
        check("t5_valid", 128'(bus.out_valid), 128'(0));
        check("t5_ir", 128'(bus.IR_out), 128'(0));

        // Bypass conflict on operand 1.
        set_idle();
        bus.in_valid = 1'b1;
        bus.VSR1 = 16'h1111;
        bus.bypass_alu_1 = 1'b1;
        bus.bypass_mem_1 = 1'b1;
        bus.alu_result_fb = 16'hA5A5;
        bus.Mem_Bypass_Val = 16'h5A5A;
        tick();
        check("t6_opA", 128'(bus.opA_out), 128'(16'hA5A5));
        check("t6_conflict", 128'(conflict_err), 128'(CONF_EN));
        set_idle();
        flush = 1'b1;
        tick();
        check("t6_conflict_flush", 128'(conflict_err), 128'(CONF_EN));
        set_idle();
        reset = 1'b1;
        tick();
        check("t6_conflict_reset", 128'(conflict_err), 128'(0));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            set_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
